// File: rtl/jk_ff_bank.sv
// jk_ff_bank: bank of WIDTH configurable JK/T/D/SR flip-flops with sticky SR-error flag and optional flip counter
// Ports: clk rising-edge clock; rst async active-low reset; clr sync clear; en update enable;
//        mode 00 JK / 01 T / 10 D / 11 SR; j J/T/D/S operand; k K/R operand;
//        q registered state; qbar ~q; flip_cnt saturating bit-flip count; sr_err sticky illegal-SR flag.
// Define JK_FF_BANK_FLIP_CNT_EN to build the flip counter; otherwise flip_cnt is tied to 0.
module jk_ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [CNT_W-1:0] flip_cnt,
  output logic             sr_err
);
  logic [WIDTH-1:0] q_nxt;
  // SR treats S=R=1 as hold; the violation is only reported through sr_err
  always_comb
    q_nxt = mode == 2'b00 ? (j & ~q) | (~k & q)
          : mode == 2'b01 ? q ^ j
          : mode == 2'b10 ? j
          :                 (j & ~k) | (q & ~(~j & k));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q      <= '0;
      sr_err <= 1'b0;
    end else if (clr) begin
      q      <= '0;
      sr_err <= 1'b0;
    end else if (en) begin
      q <= q_nxt;
      if (mode == 2'b11 && |(j & k)) sr_err <= 1'b1;
    end
  assign qbar = ~q;
`ifdef JK_FF_BANK_FLIP_CNT_EN
  // sum is wide enough to hold max count plus WIDTH flips without overflow
  localparam int SW = (CNT_W > 6 ? CNT_W : 6) + 1;
  logic [WIDTH-1:0] d;
  logic [SW-1:0]    flips;
  logic [SW-1:0]    sum;
  always_comb begin
    d     = q ^ q_nxt;
    flips = '0;
    for (int i = 0; i < WIDTH; i++) flips = flips + SW'(d[i]);
    sum   = SW'(flip_cnt) + flips;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) flip_cnt <= '0;
    else if (clr) flip_cnt <= '0;
    else if (en) flip_cnt <= |sum[SW-1:CNT_W] ? '1 : sum[CNT_W-1:0];
`else
  assign flip_cnt = '0;
`endif
endmodule

// File: doc/jk_ff_bank.md
JK_FF_BANK -- requirements
Module: jk_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of flip-flop bits, legal range 1..32.
REQ-002 SHALL have parameter CNT_W, default 16: flip-counter width, legal range 4..32.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clr, input, 1: synchronous clear of all state.
REQ-006 SHALL have port en, input, 1: update enable.
REQ-007 SHALL have port mode, input, 2: 00 JK, 01 T, 10 D, 11 SR.
REQ-008 SHALL have port j, input, WIDTH: J / T / D / S operand per bit.
REQ-009 SHALL have port k, input, WIDTH: K / R operand per bit; ignored in T and D modes.
REQ-010 SHALL have port q, output, WIDTH: registered state.
REQ-011 SHALL have port qbar, output, WIDTH: bitwise inverse of q at all times, including during reset.
REQ-012 SHALL have port flip_cnt, output, CNT_W: saturating count of bit flips (see Configuration).
REQ-013 SHALL have port sr_err, output, 1: sticky flag for an illegal SR operand.

Function
REQ-014 SHALL compute per-bit next state when en=1 and clr=0, with q' the next state:
- JK: 00 gives q' = q; 01 gives q' = 0; 10 gives q' = 1; 11 gives q' = ~q.
- T: q' = q ^ j.
- D: q' = j.
- SR: S=1,R=0 gives q' = 1; S=0,R=1 gives q' = 0; 00 gives q' = q; 11 gives q' = q.
REQ-015 SHALL hold q unchanged when en=0 and clr=0, whatever mode, j and k are.
REQ-016 SHALL, when clr=1 at a rising edge, set q=0, flip_cnt=0 and sr_err=0, regardless of en.
REQ-017 SHALL have a latency of one cycle: q reflects the operands sampled at edge N immediately after edge N.
REQ-018 SHALL set sr_err=1 on any edge where en=1, clr=0, mode=11 and (j & k) != 0.
REQ-019 SHALL keep sr_err at 1 until reset or clr; if an SR violation and clr occur on the same edge, clr wins and sr_err=0.
REQ-020 SHALL, on each edge with en=1 and clr=0, add popcount(q ^ q') to flip_cnt.
REQ-021 SHALL saturate flip_cnt at 2^CNT_W-1 and never wrap around.
REQ-022 SHALL be able to add up to WIDTH in one cycle; when the sum exceeds the maximum, flip_cnt SHALL take the maximum.
REQ-023 SHALL allow mode to change on every cycle, with each edge using only the mode sampled at that edge.

Reset
REQ-024 SHALL, while rst=0, asynchronously force q=0, qbar=all ones, flip_cnt=0 and sr_err=0.
REQ-025 SHALL, when rst is asserted mid-operation, discard any pending update.
REQ-026 SHALL apply the first update on the first rising edge after rst returns to 1.
REQ-027 SHALL have no other internal state.

Configuration
REQ-028 SHALL, with macro JK_FF_BANK_FLIP_CNT_EN defined, implement flip_cnt as in REQ-020 to REQ-022.
REQ-029 SHALL, without JK_FF_BANK_FLIP_CNT_EN, drive flip_cnt constant 0, synthesise no counter logic, and leave all other behaviour identical.

Verification
REQ-030 SHALL cover reset and T toggling:
- Stimulus: WIDTH=8; hold rst=0 for 5 cycles, release; then mode=01, j=8'hFF, en=1 for 3 edges.
- Required response: q goes 00 -> FF -> 00 -> FF, qbar is always ~q, and flip_cnt=24.
REQ-031 SHALL cover all four JK combinations:
- Stimulus: mode=00 from q=8'h0F, with j=8'hF0 and k=8'h0C at one edge.
- Required response: q=8'hF3.
- Follow-up stimulus: j=k=8'hFF.
- Required response: q=8'h0C.
REQ-032 SHALL cover the illegal SR operand and clear priority:
- Stimulus: mode=11, j=8'h01, k=8'h01.
- Required response: q is held and sr_err=1.
- Follow-up stimulus: assert clr in the same cycle as a further violation.
- Required response: sr_err=0 and q=0.
REQ-033 SHALL cover counter saturation:
- Stimulus: CNT_W=4, WIDTH=8, flag defined; toggle all bits for 2 edges.
- Required response: flip_cnt=15, and it stays at 15 after further toggles.
REQ-034 SHALL cover enable and asynchronous reset:
- Stimulus: en=0 with mode=10, j=8'hAA.
- Required response: q is unchanged.
- Follow-up stimulus: drop rst between clock edges mid-toggle.
- Required response: q=0 immediately, before the next edge.
REQ-035 SHALL cover the configuration-off build:
- Stimulus: build without JK_FF_BANK_FLIP_CNT_EN; rerun REQ-030.
- Required response: identical q and qbar, and flip_cnt=0 throughout.
